// File: rtl/iob_eth_tx_framer_pkg.sv
// Shared constants, region encodings and helpers for the Ethernet TX byte framer.
// Holds the header layout offsets and the region select used by the byte mux.
package iob_eth_tx_framer_pkg;

    localparam int ETH_HDR_LEN     = 22;
    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int ETH_MAX_PAYLOAD = 1500;

    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    localparam logic [7:0] ETH_SFD      = 8'hD5;

    // Fixed header layout: 7 preamble, SFD, dst, src, type
    localparam logic [10:0] ETH_SFD_OFF  = 11'd7;
    localparam logic [10:0] ETH_DST_OFF  = 11'd8;
    localparam logic [10:0] ETH_SRC_OFF  = 11'd14;
    localparam logic [10:0] ETH_TYPE_OFF = 11'd20;

    typedef enum logic [2:0] {
        RGN_PRE,
        RGN_SFD,
        RGN_DST,
        RGN_SRC,
        RGN_TYPE,
        RGN_PAY,
        RGN_PAD
    } region_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    function automatic logic [7:0] pick_byte(input logic [47:0] word, input logic [2:0] idx);
        return word[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/iob_eth_tx_framer.sv
// Ethernet TX byte source: maps the transmitter's byte address onto preamble, SFD,
// shadowed MAC header, payload RAM data and zero padding, with frame statistics.
module iob_eth_tx_framer
    import iob_eth_tx_framer_pkg::*;
#(
    parameter int         HDR_LEN     = ETH_HDR_LEN,
    parameter int         MIN_PAYLOAD = ETH_MIN_PAYLOAD,
    parameter int         MAX_PAYLOAD = ETH_MAX_PAYLOAD,
    parameter logic [7:0] PREAMBLE    = ETH_PREAMBLE,
    parameter logic [7:0] SFD         = ETH_SFD
) (
    input  logic        TX_CLK,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] nbytes_in,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] eth_type,
    input  logic        tx_ready,
    input  logic [10:0] addr,
    output logic [7:0]  data,
    output logic [10:0] buf_addr,
    output logic        buf_ren,
    input  logic [7:0]  buf_rdata,
    output logic [10:0] tx_nbytes,
    output logic        busy,
    output logic        len_err,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] HDR_L = 11'(HDR_LEN);
    localparam logic [10:0] MIN_L = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_L = 11'(MAX_PAYLOAD);

    state_t      state;
    state_t      state_nxt;
    logic        tx_ready_q;
    logic        ready_rise;
    logic        accept;
    logic        done;

    logic [47:0] dst_sh;
    logic [47:0] src_sh;
    logic [15:0] type_sh;
    logic [10:0] len_sh;
    logic [10:0] len_clamp;
    logic [10:0] len_padded;

    region_t     region;
    region_t     region_q;
    logic [2:0]  idx;
    logic [2:0]  idx_q;
    logic        in_pay;

    assign ready_rise = tx_ready & ~tx_ready_q;

    // State register
    always_ff @(posedge TX_CLK or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start)      state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (ready_rise) state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy   = 1'b0;
        accept = 1'b0;
        done   = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = start;
            end
            ST_ACTIVE: begin
                busy = 1'b1;
                done = ready_rise;
            end
            default: ;
        endcase
    end

    always_ff @(posedge TX_CLK or posedge rst) begin
        if (rst) begin
            tx_ready_q <= 1'b0;
        end else begin
            tx_ready_q <= tx_ready;
        end
    end

    assign len_clamp  = (nbytes_in > MAX_L) ? MAX_L : nbytes_in;
    assign len_padded = (len_clamp < MIN_L) ? MIN_L : len_clamp;

    // Frame configuration is captured only when a start is accepted in idle
    always_ff @(posedge TX_CLK or posedge rst) begin
        if (rst) begin
            dst_sh    <= '0;
            src_sh    <= '0;
            type_sh   <= '0;
            len_sh    <= '0;
            tx_nbytes <= '0;
            len_err   <= 1'b0;
        end else if (accept) begin
            dst_sh    <= dst_mac;
            src_sh    <= src_mac;
            type_sh   <= eth_type;
            len_sh    <= len_clamp;
            tx_nbytes <= len_padded;
            if (nbytes_in > MAX_L) begin
                len_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge TX_CLK or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Payload window; buf_addr wraps below the header and is ignored there
    assign buf_addr = addr - HDR_L;
    assign in_pay   = (addr >= HDR_L) && (buf_addr < len_sh);
    assign buf_ren  = busy && in_pay;

    always_comb begin
        region = RGN_PAD;
        idx    = 3'd0;
        if (addr < ETH_SFD_OFF) begin
            region = RGN_PRE;
        end else if (addr == ETH_SFD_OFF) begin
            region = RGN_SFD;
        end else if (addr < ETH_SRC_OFF) begin
            region = RGN_DST;
            idx    = 3'(ETH_DST_OFF + 11'd5 - addr);
        end else if (addr < ETH_TYPE_OFF) begin
            region = RGN_SRC;
            idx    = 3'(ETH_SRC_OFF + 11'd5 - addr);
        end else if (addr < HDR_L) begin
            region = RGN_TYPE;
            idx    = 3'(ETH_TYPE_OFF + 11'd1 - addr);
        end else if (in_pay) begin
            region = RGN_PAY;
        end
    end

    // Region select registered alongside the RAM read so every byte lands one cycle after addr
    always_ff @(posedge TX_CLK or posedge rst) begin
        if (rst) begin
            region_q <= RGN_PAD;
            idx_q    <= 3'd0;
        end else begin
            region_q <= region;
            idx_q    <= idx;
        end
    end

    always_comb begin
        data = 8'h00;
        case (region_q)
            RGN_PRE:  data = PREAMBLE;
            RGN_SFD:  data = SFD;
            RGN_DST:  data = pick_byte(dst_sh, idx_q);
            RGN_SRC:  data = pick_byte(src_sh, idx_q);
            RGN_TYPE: data = idx_q[0] ? type_sh[15:8] : type_sh[7:0];
            RGN_PAY:  data = buf_rdata;
            default:  data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_iob_eth_tx_framer.sv
// Directed bench for iob_eth_tx_framer: a behavioural payload RAM, a reference byte
// map, and a queue of expected bytes compared one cycle after each address.
module tb_iob_eth_tx_framer;

    logic        TX_CLK;
    logic        rst;
    logic        start;
    logic [10:0] nbytes_in;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic        tx_ready;
    logic [10:0] addr;
    logic [7:0]  data;
    logic [10:0] buf_addr;
    logic        buf_ren;
    logic [7:0]  buf_rdata;
    logic [10:0] tx_nbytes;
    logic        busy;
    logic        len_err;
    logic [15:0] frame_cnt;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]  ram [0:2047];
    logic [7:0]  exp_q [$];
    int          addr_q [$];

    logic [47:0] m_dst  = '0;
    logic [47:0] m_src  = '0;
    logic [15:0] m_type = '0;
    int          m_len  = 0;
    logic [15:0] m_cnt  = '0;

    iob_eth_tx_framer dut (
        .TX_CLK    (TX_CLK),
        .rst       (rst),
        .start     (start),
        .nbytes_in (nbytes_in),
        .dst_mac   (dst_mac),
        .src_mac   (src_mac),
        .eth_type  (eth_type),
        .tx_ready  (tx_ready),
        .addr      (addr),
        .data      (data),
        .buf_addr  (buf_addr),
        .buf_ren   (buf_ren),
        .buf_rdata (buf_rdata),
        .tx_nbytes (tx_nbytes),
        .busy      (busy),
        .len_err   (len_err),
        .frame_cnt (frame_cnt)
    );

    initial TX_CLK = 1'b0;
    always #5 TX_CLK = ~TX_CLK;

    // External payload RAM: synchronous read, one cycle latency
    always @(posedge TX_CLK) begin
        if (buf_ren) buf_rdata <= ram[buf_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input int a);
        if (a < 7)            return 8'h55;
        else if (a == 7)      return 8'hD5;
        else if (a < 14)      return m_dst[8*(13-a) +: 8];
        else if (a < 20)      return m_src[8*(19-a) +: 8];
        else if (a < 22)      return m_type[8*(21-a) +: 8];
        else if (a < 22 + m_len) return ram[a-22];
        else                  return 8'h00;
    endfunction

    task automatic pop_check();
        logic [7:0] e;
        int         a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = addr_q.pop_front();
            chk($sformatf("data@%0d", a), {24'h0, data}, {24'h0, e});
        end
    endtask

    task automatic step(input int a, input bit ren_chk);
        @(negedge TX_CLK);
        pop_check();
        addr = 11'(a);
        exp_q.push_back(model(a));
        addr_q.push_back(a);
        if (ren_chk) begin
            #1;
            chk($sformatf("buf_ren@%0d", a), {31'h0, buf_ren},
                {31'h0, (a >= 22 && a < 22 + m_len) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic sweep(input int lo, input int hi, input bit ren_chk);
        for (int a = lo; a <= hi; a++) step(a, ren_chk);
        @(negedge TX_CLK);
        pop_check();
    endtask

    task automatic start_frame(input int n);
        int exp_tx;
        @(negedge TX_CLK);
        nbytes_in = 11'(n);
        start     = 1'b1;
        m_dst  = dst_mac;
        m_src  = src_mac;
        m_type = eth_type;
        m_len  = (n > 1500) ? 1500 : n;
        exp_tx = (m_len < 46) ? 46 : m_len;
        @(negedge TX_CLK);
        start = 1'b0;
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        chk($sformatf("tx_nbytes_n%0d", n), {21'h0, tx_nbytes}, exp_tx);
    endtask

    task automatic end_frame();
        @(negedge TX_CLK);
        tx_ready = 1'b1;
        m_cnt = m_cnt + 16'd1;
        @(negedge TX_CLK);
        tx_ready = 1'b0;
        chk("busy_after_done", {31'h0, busy}, 32'h0);
        chk("frame_cnt", {16'h0, frame_cnt}, {16'h0, m_cnt});
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i * 37 + 11);
        rst       = 1'b1;
        start     = 1'b0;
        nbytes_in = '0;
        dst_mac   = 48'h0A1B2C3D4E5F;
        src_mac   = 48'h112233445566;
        eth_type  = 16'h0800;
        tx_ready  = 1'b0;
        addr      = '0;

        // Reset values
        repeat (2) @(negedge TX_CLK);
        chk("rst_data", {24'h0, data}, 32'h0);
        chk("rst_tx_nbytes", {21'h0, tx_nbytes}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_len_err", {31'h0, len_err}, 32'h0);
        chk("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
        rst = 1'b0;

        // Full frame, 100 payload bytes
        start_frame(100);
        sweep(0, 121, 1'b0);
        end_frame();

        // Short payload padded to 46, RAM read enable limited to the real payload
        start_frame(10);
        sweep(0, 67, 1'b1);
        chk("len_err_ok", {31'h0, len_err}, 32'h0);
        end_frame();

        // Oversize request clamped, sticky error
        start_frame(1600);
        chk("len_err_set", {31'h0, len_err}, 32'h1);
        sweep(18, 26, 1'b0);
        sweep(1518, 1525, 1'b1);
        end_frame();

        start_frame(60);
        chk("len_err_sticky", {31'h0, len_err}, 32'h1);

        // Config changes and a second start while busy are ignored
        @(negedge TX_CLK);
        dst_mac   = 48'hDEADBEEFCAFE;
        nbytes_in = 11'd5;
        start     = 1'b1;
        @(negedge TX_CLK);
        start = 1'b0;
        chk("tx_nbytes_hold", {21'h0, tx_nbytes}, 32'd60);
        chk("busy_hold", {31'h0, busy}, 32'h1);
        sweep(0, 90, 1'b1);
        end_frame();
        chk("tx_nbytes_idle_hold", {21'h0, tx_nbytes}, 32'd60);

        // Zero-length payload, all padding
        start_frame(0);
        sweep(6, 70, 1'b1);
        end_frame();

        // Exactly minimum payload, no padding
        start_frame(46);
        sweep(8, 13, 1'b0);
        sweep(64, 70, 1'b1);
        end_frame();

        // Counter wrap
        @(negedge TX_CLK);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge TX_CLK);
        release dut.frame_cnt;
        m_cnt = 16'hFFFF;
        @(negedge TX_CLK);
        chk("frame_cnt_preload", {16'h0, frame_cnt}, 32'hFFFF);
        start_frame(1);
        sweep(20, 24, 1'b0);
        end_frame();

        // Reset mid-frame aborts
        start_frame(100);
        sweep(0, 30, 1'b0);
        @(negedge TX_CLK);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_data", {24'h0, data}, 32'h0);
        chk("abort_tx_nbytes", {21'h0, tx_nbytes}, 32'h0);
        chk("abort_frame_cnt", {16'h0, frame_cnt}, 32'h0);
        chk("abort_len_err", {31'h0, len_err}, 32'h0);
        repeat (2) @(negedge TX_CLK);
        rst = 1'b0;
        @(negedge TX_CLK);
        chk("post_abort_busy", {31'h0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
